clock_set_controller: RTL

//  Time-setting sequencer for the Mojo clock. Consumes debounced press/long-press pulses from three

---
 rtl/clkset_pkg.sv | 43 ++++
 rtl/auto_repeat.sv | 48 ++++
 rtl/clock_set_controller.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/clkset_pkg.sv
// Shared types and helpers for the clock time-setting sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, display field codes, hour/minute limits,
// a counter-width helper for parameter-sized timers, and wrap-around
// step functions that stay at field width.
package clkset_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_COMMIT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FLD_NONE = 2'd0,
    FLD_HR   = 2'd1,
    FLD_MIN  = 2'd2
  } field_t;

  localparam logic [4:0] HR_MAX  = 5'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;

  // Width of a counter that must hold 0..n-1 (never narrower than 1 bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One hour step with 23->0 / 0->23 wrap.
  function automatic logic [4:0] hr_step(input logic [4:0] v, input logic up);
    if (up) return (v == HR_MAX) ? 5'd0 : v + 5'd1;
    else    return (v == 5'd0) ? HR_MAX : v - 5'd1;
  endfunction

  // One minute step with 59->0 / 0->59 wrap.
  function automatic logic [5:0] min_step(input logic [5:0] v, input logic up);
    if (up) return (v == MIN_MAX) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? MIN_MAX : v - 6'd1;
  endfunction

endpackage

// File: rtl/auto_repeat.sv
// Auto-repeat step generator for one UP/DOWN button (built only with CLKSET_AUTOREPEAT_EN).
// Latency: first step combinational in the start cycle, then one step every REPEAT_CYC cycles.
// Backpressure: none; step is a 1-cycle pulse, repeat stops when held or enable drops.
//
// Ports: clk, rst_n (async active-low); start = long-press pulse; held = button level;
//        enable = owner is in an edit state and not cancelling; step = 1-cycle step pulse.
`ifdef CLKSET_AUTOREPEAT_EN
module auto_repeat
  import clkset_pkg::*;
#(
  parameter int REPEAT_CYC = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic held,
  input  logic enable,
  output logic step
);

  localparam int RW = cnt_w(REPEAT_CYC);

  logic          active;
  logic [RW-1:0] cnt;
  logic          wrap;

  assign wrap = active && (cnt == RW'(REPEAT_CYC - 1));
  assign step = enable && held && (start || wrap);

  // Dropping held or enable parks the generator so a later long press
  // always restarts with an immediate step and a full interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (!enable || !held) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
    end else if (active) begin
      cnt <= wrap ? '0 : cnt + RW'(1);
    end
  end

endmodule
`endif

// File: rtl/clock_set_controller.sv
// Time-setting sequencer: MODE/UP/DOWN pulses edit a shadow HH:MM and commit it with a load strobe.
// Latency: every output is registered, responding 1 cycle after the input pulse.
// Backpressure: none; inputs are 1-cycle pulses, load is a 1-cycle strobe the counter must accept.
//
// Ports: clk, rst_n (async active-low)
//   in : mode_press, mode_long, up_press, down_press, up_long, down_long (pulses),
//        up_held, down_held (levels), cur_hr[4:0], cur_min[5:0] (live time)
//   out: set_active, field[1:0] (0 none/1 hr/2 min), blink, shadow_hr/min,
//        load, load_hr/min
// Build option: define CLKSET_AUTOREPEAT_EN to add long-press auto-repeat on UP/DOWN;
// without it only up_press/down_press step and *_long/*_held are ignored.
module clock_set_controller
  import clkset_pkg::*;
#(
  parameter int TIMEOUT_CYC = 500_000_000,
  parameter int REPEAT_CYC  = 5_000_000,
  parameter int BLINK_CYC   = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_press,
  input  logic       mode_long,
  input  logic       up_press,
  input  logic       down_press,
  input  logic       up_long,
  input  logic       down_long,
  input  logic       up_held,
  input  logic       down_held,
  input  logic [4:0] cur_hr,
  input  logic [5:0] cur_min,
  output logic       set_active,
  output logic [1:0] field,
  output logic       blink,
  output logic [4:0] shadow_hr,
  output logic [5:0] shadow_min,
  output logic       load,
  output logic [4:0] load_hr,
  output logic [5:0] load_min
);

  localparam int TO_W = cnt_w(TIMEOUT_CYC);
  localparam int BL_W = cnt_w(BLINK_CYC);

  state_t state, state_nxt;

  logic            in_set, in_set_nxt;
  logic            up_step, down_step;
  logic            any_evt;
  logic            timeout;
  logic [TO_W-1:0] idle_cnt;
  logic [BL_W-1:0] blink_cnt;
  logic [4:0]      shadow_hr_nxt;
  logic [5:0]      shadow_min_nxt;

  assign in_set     = (state == ST_SET_HR) || (state == ST_SET_MIN);
  assign in_set_nxt = (state_nxt == ST_SET_HR) || (state_nxt == ST_SET_MIN);

`ifdef CLKSET_AUTOREPEAT_EN
  logic ar_enable;
  logic ar_up_step, ar_down_step;

  // A mode event this cycle means the state is about to change, and both
  // buttons down is a conflicting request; either one parks the repeaters.
  assign ar_enable = in_set && !(up_held && down_held) && !mode_press && !mode_long;

  auto_repeat #(.REPEAT_CYC(REPEAT_CYC)) u_ar_up (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (up_long),
    .held   (up_held),
    .enable (ar_enable),
    .step   (ar_up_step)
  );

  auto_repeat #(.REPEAT_CYC(REPEAT_CYC)) u_ar_down (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (down_long),
    .held   (down_held),
    .enable (ar_enable),
    .step   (ar_down_step)
  );

  assign up_step   = up_press | ar_up_step;
  assign down_step = down_press | ar_down_step;
  assign any_evt   = mode_press | mode_long | up_step | down_step | up_long | down_long;
`else
  logic unused_inputs;
  localparam int unused_repeat_cyc = REPEAT_CYC;

  assign unused_inputs = ^{up_long, down_long, up_held, down_held};
  assign up_step       = up_press;
  assign down_step     = down_press;
  assign any_evt       = mode_press | mode_long | up_step | down_step;
`endif

  assign timeout = (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next state and shadow edit. Mode events take priority over steps, and a
  // simultaneous up+down cancels out.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    shadow_hr_nxt  = shadow_hr;
    shadow_min_nxt = shadow_min;

    case (state)
      ST_RUN: begin
        if (mode_long) begin
          state_nxt      = ST_SET_HR;
          shadow_hr_nxt  = cur_hr;
          shadow_min_nxt = cur_min;
        end
      end
      ST_SET_HR: begin
        if (mode_long)                 state_nxt = ST_RUN;
        else if (mode_press)           state_nxt = ST_SET_MIN;
        else if (up_step ^ down_step)  shadow_hr_nxt = hr_step(shadow_hr, up_step);
        else if (!any_evt && timeout)  state_nxt = ST_RUN;
      end
      ST_SET_MIN: begin
        if (mode_long)                 state_nxt = ST_RUN;
        else if (mode_press)           state_nxt = ST_COMMIT;
        else if (up_step ^ down_step)  shadow_min_nxt = min_step(shadow_min, up_step);
        else if (!any_evt && timeout)  state_nxt = ST_RUN;
      end
      ST_COMMIT: state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, derived from the next state so they line up with it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_active <= 1'b0;
      field      <= FLD_NONE;
      shadow_hr  <= '0;
      shadow_min <= '0;
      load       <= 1'b0;
      load_hr    <= '0;
      load_min   <= '0;
    end else begin
      set_active <= in_set_nxt;
      case (state_nxt)
        ST_SET_HR:  field <= FLD_HR;
        ST_SET_MIN: field <= FLD_MIN;
        default:    field <= FLD_NONE;
      endcase
      shadow_hr  <= shadow_hr_nxt;
      shadow_min <= shadow_min_nxt;
      load       <= (state_nxt == ST_COMMIT);
      if (state_nxt == ST_COMMIT) begin
        load_hr  <= shadow_hr;
        load_min <= shadow_min;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Idle timeout counter: counts quiet cycles inside an edit state only.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       idle_cnt <= '0;
    else if (!in_set_nxt || !in_set || any_evt)       idle_cnt <= '0;
    else                                              idle_cnt <= idle_cnt + TO_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Blink: any user event restarts the phase lit, so the edited digits are
  // visible right after they change.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (!in_set_nxt) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (any_evt || !in_set) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (blink_cnt == BL_W'(BLINK_CYC - 1)) begin
      blink     <= ~blink;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BL_W'(1);
    end
  end

endmodule
